// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
//
// Sequencing controller for the UART matrix-multiplication datapath.
// Receives three dimension bytes (M, K, N), validates them, streams the M*K
// elements of A and the K*N elements of B into the operand memories, starts
// the multiplier, then paces the M*N results out through the UART transmitter
// one element per transfer.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   abort             synchronous abort back to IDLE (clears counters and err)
//   rx_valid/rx_data  received-byte strobe and data
//   tx_busy           UART transmitter busy
//   mult_done         multiplier finished (level or pulse)
//   rx_enable         controller is accepting RX bytes
//   mem_we/mem_sel/mem_addr/mem_wdata
//                     operand memory write port (combinational, same cycle
//                     as rx_valid; mem_sel 0 = A, 1 = B)
//   m_dim/k_dim/n_dim latched dimensions
//   mult_start        one-cycle multiplier start pulse
//   tx_start/res_addr one-cycle transmit pulse and the result index it sends
//   done              one-cycle pulse after the last result has been sent
//   err               sticky dimension error
//   current_state     state code
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 8,
    parameter int DIM_W   = $clog2(MAX_DIM + 1),
    parameter int ADDR_W  = ((MAX_DIM * MAX_DIM) > 1) ? $clog2(MAX_DIM * MAX_DIM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    input  logic              mult_done,
    output logic              rx_enable,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DIM_W-1:0]  m_dim,
    output logic [DIM_W-1:0]  k_dim,
    output logic [DIM_W-1:0]  n_dim,
    output logic              mult_start,
    output logic              tx_start,
    output logic [ADDR_W-1:0] res_addr,
    output logic              done,
    output logic              err,
    output logic [2:0]        current_state
);

    // Element counters run at the full product width so the last-index
    // compare never loses bits.
    localparam int CNT_W = 2 * DIM_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DIMS      = 3'd1,
        S_LOAD_A    = 3'd2,
        S_LOAD_B    = 3'd3,
        S_COMPUTE   = 3'd4,
        S_SEND      = 3'd5,
        S_SEND_WAIT = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  elem_cnt_r, elem_cnt_s;
    logic [CNT_W-1:0]  res_cnt_r, res_cnt_s;
    logic [1:0]        dim_idx_r, dim_idx_s;
    logic [DIM_W-1:0]  m_dim_r, m_dim_s;
    logic [DIM_W-1:0]  k_dim_r, k_dim_s;
    logic [DIM_W-1:0]  n_dim_r, n_dim_s;
    logic              dim_bad_r, dim_bad_s;
    logic              err_r, err_s;
    logic              mult_start_r, mult_start_s;
    logic              tx_start_r, tx_start_s;
    logic              done_r, done_s;
    logic [ADDR_W-1:0] res_addr_r, res_addr_s;
    logic [CNT_W-1:0]  mk_s, kn_s, mn_s;

    // A dimension byte is legal only if 1..MAX_DIM over the full byte width;
    // checking the raw byte keeps e.g. 24 from aliasing to a legal 8 after
    // truncation to DIM_W bits.
    function automatic logic dim_in_range(input logic [DATA_W-1:0] b);
        return (b != {DATA_W{1'b0}}) && (b <= DATA_W'(MAX_DIM));
    endfunction

    // Operand and result counts for the latched job.
    always_comb begin
        mk_s = CNT_W'(m_dim_r) * CNT_W'(k_dim_r);
        kn_s = CNT_W'(k_dim_r) * CNT_W'(n_dim_r);
        mn_s = CNT_W'(m_dim_r) * CNT_W'(n_dim_r);
    end

    // RX handshake and operand-memory write port, decoded from the state.
    always_comb begin
        rx_enable = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 1'b0;
        mem_addr  = elem_cnt_r[ADDR_W-1:0];
        mem_wdata = rx_data;
        case (state_r)
            S_IDLE, S_DIMS: begin
                rx_enable = 1'b1;
            end
            S_LOAD_A: begin
                rx_enable = 1'b1;
                mem_we    = rx_valid & ~abort;
            end
            S_LOAD_B: begin
                rx_enable = 1'b1;
                mem_we    = rx_valid & ~abort;
                mem_sel   = 1'b1;
            end
            default: begin
                rx_enable = 1'b0;
            end
        endcase
    end

    // Next-state, counter and registered-pulse logic.
    always_comb begin
        state_s      = state_r;
        elem_cnt_s   = elem_cnt_r;
        res_cnt_s    = res_cnt_r;
        dim_idx_s    = dim_idx_r;
        m_dim_s      = m_dim_r;
        k_dim_s      = k_dim_r;
        n_dim_s      = n_dim_r;
        dim_bad_s    = dim_bad_r;
        err_s        = err_r;
        res_addr_s   = res_addr_r;
        mult_start_s = 1'b0;
        tx_start_s   = 1'b0;
        done_s       = 1'b0;

        if (abort) begin
            // Abort overrides everything; dims are deliberately kept.
            state_s    = S_IDLE;
            elem_cnt_s = {CNT_W{1'b0}};
            res_cnt_s  = {CNT_W{1'b0}};
            dim_idx_s  = 2'd0;
            dim_bad_s  = 1'b0;
            err_s      = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (rx_valid) begin
                        m_dim_s   = rx_data[DIM_W-1:0];
                        dim_bad_s = ~dim_in_range(rx_data);
                        dim_idx_s = 2'd1;
                        state_s   = S_DIMS;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_DIMS: begin
                    if (rx_valid) begin
                        if (dim_idx_r == 2'd1) begin
                            k_dim_s   = rx_data[DIM_W-1:0];
                            dim_bad_s = dim_bad_r | ~dim_in_range(rx_data);
                            dim_idx_s = 2'd2;
                        end else begin
                            n_dim_s   = rx_data[DIM_W-1:0];
                            dim_idx_s = 2'd0;
                            if (dim_bad_r || !dim_in_range(rx_data)) begin
                                state_s = S_ERROR;
                                err_s   = 1'b1;
                            end else begin
                                state_s    = S_LOAD_A;
                                elem_cnt_s = {CNT_W{1'b0}};
                            end
                        end
                    end else begin
                        state_s = S_DIMS;
                    end
                end
                S_LOAD_A: begin
                    if (rx_valid) begin
                        if (elem_cnt_r == (mk_s - CNT_W'(1))) begin
                            elem_cnt_s = {CNT_W{1'b0}};
                            state_s    = S_LOAD_B;
                        end else begin
                            elem_cnt_s = elem_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_s = S_LOAD_A;
                    end
                end
                S_LOAD_B: begin
                    if (rx_valid) begin
                        if (elem_cnt_r == (kn_s - CNT_W'(1))) begin
                            elem_cnt_s   = {CNT_W{1'b0}};
                            state_s      = S_COMPUTE;
                            mult_start_s = 1'b1;
                        end else begin
                            elem_cnt_s = elem_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_s = S_LOAD_B;
                    end
                end
                S_COMPUTE: begin
                    // mult_start_r is high exactly in the first COMPUTE cycle,
                    // so it doubles as the "ignore mult_done" qualifier.
                    if (!mult_start_r && mult_done) begin
                        state_s   = S_SEND;
                        res_cnt_s = {CNT_W{1'b0}};
                    end else begin
                        state_s = S_COMPUTE;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        state_s    = S_SEND_WAIT;
                        tx_start_s = 1'b1;
                        res_addr_s = res_cnt_r[ADDR_W-1:0];
                    end else begin
                        state_s = S_SEND;
                    end
                end
                S_SEND_WAIT: begin
                    // The transmitter may not raise tx_busy until the cycle
                    // after tx_start, so the first cycle (tx_start_r high)
                    // never exits.
                    if (tx_start_r) begin
                        state_s = S_SEND_WAIT;
                    end else if (!tx_busy) begin
                        if (res_cnt_r == (mn_s - CNT_W'(1))) begin
                            state_s = S_IDLE;
                            done_s  = 1'b1;
                        end else begin
                            res_cnt_s = res_cnt_r + CNT_W'(1);
                            state_s   = S_SEND;
                        end
                    end else begin
                        state_s = S_SEND_WAIT;
                    end
                end
                S_ERROR: begin
                    state_s = S_ERROR;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, latched dimensions and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            elem_cnt_r   <= {CNT_W{1'b0}};
            res_cnt_r    <= {CNT_W{1'b0}};
            dim_idx_r    <= 2'd0;
            m_dim_r      <= {DIM_W{1'b0}};
            k_dim_r      <= {DIM_W{1'b0}};
            n_dim_r      <= {DIM_W{1'b0}};
            dim_bad_r    <= 1'b0;
            err_r        <= 1'b0;
            mult_start_r <= 1'b0;
            tx_start_r   <= 1'b0;
            done_r       <= 1'b0;
            res_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r      <= state_s;
            elem_cnt_r   <= elem_cnt_s;
            res_cnt_r    <= res_cnt_s;
            dim_idx_r    <= dim_idx_s;
            m_dim_r      <= m_dim_s;
            k_dim_r      <= k_dim_s;
            n_dim_r      <= n_dim_s;
            dim_bad_r    <= dim_bad_s;
            err_r        <= err_s;
            mult_start_r <= mult_start_s;
            tx_start_r   <= tx_start_s;
            done_r       <= done_s;
            res_addr_r   <= res_addr_s;
        end
    end

    assign m_dim         = m_dim_r;
    assign k_dim         = k_dim_r;
    assign n_dim         = n_dim_r;
    assign mult_start    = mult_start_r;
    assign tx_start      = tx_start_r;
    assign res_addr      = res_addr_r;
    assign done          = done_r;
    assign err           = err_r;
    assign current_state = state_r;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//
// Self-checking bench for matmul_seq_ctrl. A table of dimension cases (legal
// and illegal) plus randomized jobs are run against a job-level reference:
// the expected write stream, start pulse, result indices, pulse spacing and
// done timing are computed from M, K, N, the operand bytes and the behaviour
// of a simple transmitter model. Hand-written sequences cover abort, a long
// tx_busy stall, the guard cycle and reset in the middle of sending.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    localparam int DATA_W  = 8;
    localparam int MAX_DIM = 8;
    localparam int DIM_W   = $clog2(MAX_DIM + 1);
    localparam int ADDR_W  = $clog2(MAX_DIM * MAX_DIM);

    logic              clk = 1'b0;
    logic              rst;
    logic              abort;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              tx_busy;
    logic              mult_done;
    logic              rx_enable;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DIM_W-1:0]  m_dim;
    logic [DIM_W-1:0]  k_dim;
    logic [DIM_W-1:0]  n_dim;
    logic              mult_start;
    logic              tx_start;
    logic [ADDR_W-1:0] res_addr;
    logic              done;
    logic              err;
    logic [2:0]        current_state;

    matmul_seq_ctrl #(
        .DATA_W (DATA_W),
        .MAX_DIM(MAX_DIM),
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .abort        (abort),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_busy      (tx_busy),
        .mult_done    (mult_done),
        .rx_enable    (rx_enable),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .m_dim        (m_dim),
        .k_dim        (k_dim),
        .n_dim        (n_dim),
        .mult_start   (mult_start),
        .tx_start     (tx_start),
        .res_addr     (res_addr),
        .done         (done),
        .err          (err),
        .current_state(current_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Event log filled by tick()
    int wr_log[$];
    int tx_q[$];
    int tx_cyc_q[$];
    int ms_cnt;
    int ms_cyc;
    int done_cnt;
    int done_cyc;

    typedef struct {
        int m;
        int k;
        int n;
        int busy;
        int dly;
        int exp_err;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_log.delete();
        tx_q.delete();
        tx_cyc_q.delete();
        ms_cnt   = 0;
        ms_cyc   = -1;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // One clock cycle: sample outputs at the falling edge, then step past
    // the rising edge; inputs are changed only between ticks.
    task automatic tick();
        @(negedge clk);
        if (mem_we === 1'b1) begin
            wr_log.push_back((int'(mem_sel) << 16) | (int'(mem_addr) << 8) | int'(mem_wdata));
        end
        if (mult_start === 1'b1) begin
            ms_cnt++;
            ms_cyc = cyc;
        end
        if (tx_start === 1'b1) begin
            tx_q.push_back(int'(res_addr));
            tx_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Complete legal job against the job-level reference.
    task automatic run_job(input int m, input int k, input int n, input int busy_len,
                           input int done_dly, input int gap_max, input string tag);
        int bytes[$];
        int last_byte_cyc;
        int md_cyc;
        int busy_left;
        int ntx;
        int guard;
        int exp_w;
        clear_log();
        bytes.push_back(m);
        bytes.push_back(k);
        bytes.push_back(n);
        for (int i = 0; i < m * k + k * n; i++) bytes.push_back($urandom_range(255, 0));
        last_byte_cyc = 0;
        foreach (bytes[i]) begin
            rx_valid = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
            rx_valid      = 1'b1;
            rx_data       = DATA_W'(bytes[i]);
            last_byte_cyc = cyc;
            tick();
        end
        rx_valid  = 1'b0;
        md_cyc    = -1;
        busy_left = 0;
        guard     = 0;
        while (done_cnt == 0 && guard < 5000) begin
            ntx       = tx_q.size();
            mult_done = (ms_cnt == 1 && md_cyc < 0 && cyc == ms_cyc + done_dly);
            if (mult_done) md_cyc = cyc;
            tx_busy   = (busy_left > 0);
            // Stray RX bytes while computing/sending must be ignored.
            rx_valid  = (tx_q.size() < m * n) ? 1'($urandom_range(1, 0)) : 1'b0;
            rx_data   = DATA_W'($urandom_range(255, 0));
            tick();
            mult_done = 1'b0;
            if (tx_q.size() != ntx) busy_left = busy_len;
            else if (busy_left > 0) busy_left--;
            guard++;
        end
        rx_valid = 1'b0;
        tx_busy  = 1'b0;

        chk($sformatf("%s_nwrites", tag), wr_log.size(), m * k + k * n);
        for (int i = 0; i < wr_log.size() && i < m * k + k * n; i++) begin
            if (i < m * k) exp_w = (i << 8) | bytes[3 + i];
            else           exp_w = 32'h10000 | ((i - m * k) << 8) | bytes[3 + i];
            chk($sformatf("%s_write%0d", tag, i), wr_log[i], exp_w);
        end
        chk($sformatf("%s_mult_start_cnt", tag), ms_cnt, 1);
        chk($sformatf("%s_mult_start_lat", tag), ms_cyc, last_byte_cyc + 1);
        chk($sformatf("%s_ntx", tag), tx_q.size(), m * n);
        foreach (tx_q[i]) chk($sformatf("%s_res_addr%0d", tag, i), tx_q[i], i);
        if (tx_cyc_q.size() > 0) begin
            chk($sformatf("%s_first_tx_lat", tag), tx_cyc_q[0], md_cyc + 2);
            chk($sformatf("%s_done_lat", tag), done_cyc, tx_cyc_q[tx_cyc_q.size() - 1] + busy_len + 2);
        end
        for (int i = 1; i < tx_cyc_q.size(); i++)
            chk($sformatf("%s_tx_spacing%0d", tag, i), tx_cyc_q[i] - tx_cyc_q[i - 1], busy_len + 3);
        chk($sformatf("%s_done_cnt", tag), done_cnt, 1);
        chk($sformatf("%s_end_state", tag), current_state, 0);
        chk($sformatf("%s_err", tag), err, 0);
        chk($sformatf("%s_dims", tag), {m_dim, k_dim, n_dim}, (m << (2 * DIM_W)) | (k << DIM_W) | n);
    endtask

    // Illegal dimensions: ERROR right after the third byte, RX ignored, abort recovers.
    task automatic run_err(input int m, input int k, input int n, input string tag);
        int d[3];
        clear_log();
        d[0] = m;
        d[1] = k;
        d[2] = n;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = DATA_W'(d[i]);
            tick();
        end
        chk($sformatf("%s_state", tag), current_state, 7);
        chk($sformatf("%s_err_set", tag), err, 1);
        for (int i = 0; i < 5; i++) begin
            rx_data = DATA_W'($urandom_range(255, 0));
            tick();
        end
        rx_valid = 1'b0;
        chk($sformatf("%s_no_writes", tag), wr_log.size(), 0);
        chk($sformatf("%s_no_mult_start", tag), ms_cnt, 0);
        chk($sformatf("%s_rx_enable", tag), rx_enable, 0);
        chk($sformatf("%s_err_sticky", tag), err, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk($sformatf("%s_abort_state", tag), current_state, 0);
        chk($sformatf("%s_abort_err", tag), err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{m: 2,  k: 3, n: 2,   busy: 4, dly: 5, exp_err: 0};
        tbl[1] = '{m: 1,  k: 1, n: 1,   busy: 0, dly: 1, exp_err: 0};
        tbl[2] = '{m: 3,  k: 9, n: 2,   busy: 0, dly: 1, exp_err: 1};
        tbl[3] = '{m: 0,  k: 4, n: 4,   busy: 0, dly: 1, exp_err: 1};
        tbl[4] = '{m: 1,  k: 8, n: 8,   busy: 2, dly: 3, exp_err: 0};
        tbl[5] = '{m: 24, k: 1, n: 1,   busy: 0, dly: 1, exp_err: 1};
        tbl[6] = '{m: 2,  k: 2, n: 16,  busy: 0, dly: 1, exp_err: 1};
        tbl[7] = '{m: 8,  k: 8, n: 8,   busy: 1, dly: 2, exp_err: 0};
        tbl[8] = '{m: 4,  k: 4, n: 255, busy: 0, dly: 1, exp_err: 1};

        rst       = 1'b1;
        abort     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        tx_busy   = 1'b0;
        mult_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk("rst_state", current_state, 0);
        chk("rst_rx_enable", rx_enable, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_pulses", {mult_start, tx_start, done, err}, 0);
        chk("rst_res_addr", res_addr, 0);
        chk("rst_dims", {m_dim, k_dim, n_dim}, 0);

        // Dimension table, back-to-back bytes
        foreach (tbl[i]) begin
            if (tbl[i].exp_err != 0)
                run_err(tbl[i].m, tbl[i].k, tbl[i].n, $sformatf("tbl%0d", i));
            else
                run_job(tbl[i].m, tbl[i].k, tbl[i].n, tbl[i].busy, tbl[i].dly, 0,
                        $sformatf("tbl%0d", i));
        end

        // Abort in LOAD_B after 3 of 4 B bytes, then a fresh 2,2,2 job
        clear_log();
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx_data = (i < 3) ? 8'd2 : DATA_W'(i);
            tick();
        end
        rx_valid = 1'b0;
        chk("abort_pre_state", current_state, 3);
        chk("abort_pre_writes", wr_log.size(), 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", current_state, 0);
        chk("abort_dims_kept", {m_dim, k_dim, n_dim}, (2 << (2 * DIM_W)) | (2 << DIM_W) | 2);
        chk("abort_no_mult_start", ms_cnt, 0);
        run_job(2, 2, 2, 1, 2, 1, "after_abort");

        // Long tx_busy stall in SEND, mult_done ignored in first COMPUTE cycle,
        // busy high during the guard cycle.
        clear_log();
        tx_busy  = 1'b1;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data = (i < 3) ? 8'd1 : 8'd77;
            tick();
        end
        rx_valid = 1'b0;
        chk("stall_mult_start", mult_start, 1);
        mult_done = 1'b1;
        tick();
        chk("stall_first_compute_ignored", current_state, 4);
        tick();
        mult_done = 1'b0;
        chk("stall_to_send", current_state, 5);
        repeat (50) tick();
        chk("stall_no_tx", tx_q.size(), 0);
        chk("stall_still_send", current_state, 5);
        tx_busy = 1'b0;
        tick();
        chk("stall_tx_start", tx_start, 1);
        chk("stall_send_wait", current_state, 6);
        tx_busy = 1'b1;
        tick();
        chk("guard_hold", current_state, 6);
        tx_busy = 1'b0;
        tick();
        chk("guard_done", done, 1);
        chk("guard_idle", current_state, 0);

        // Reset asserted while in SEND
        clear_log();
        rx_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            rx_data = (i < 3) ? 8'd2 : 8'd5;
            tick();
        end
        rx_valid = 1'b0;
        tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        for (int g = 0; g < 50 && tx_q.size() < 2; g++) tick();
        tick();
        tx_busy = 1'b1;
        tick();
        chk("rstmid_in_send", current_state, 5);
        chk("rstmid_res_addr_before", res_addr, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_state", current_state, 0);
        chk("rstmid_res_addr", res_addr, 0);
        chk("rstmid_dims", {m_dim, k_dim, n_dim}, 0);
        chk("rstmid_outs", {rx_enable, mult_start, tx_start, done, err}, 5'b10000);
        tick();
        rst     = 1'b0;
        tx_busy = 1'b0;

        // Randomized legal jobs
        for (int r = 0; r < 6; r++) begin
            run_job($urandom_range(MAX_DIM, 1), $urandom_range(MAX_DIM, 1),
                    $urandom_range(MAX_DIM, 1), $urandom_range(5, 0),
                    $urandom_range(6, 1), $urandom_range(2, 0), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Parametrised sequencing controller for the UART matrix-multiplication datapath. It receives three dimension bytes (M, K, N) over UART and validates them. It then streams the M×K elements of A and the K×N elements of B into the operand memories, starts the multiplier, and paces the M×N results out through the UART transmitter one element per transfer. It supports rectangular operands up to MAX_DIM, dimension-error detection with sticky status, and a synchronous abort.

## Interface
- DATA_W, 8, width of rx_data and operand elements
- MAX_DIM, 8, largest legal value of M, K or N (≥1)
- DIM_W, $clog2(MAX_DIM+1), width of dimension outputs
- ADDR_W, $clog2(MAX_DIM*MAX_DIM) (min 1), width of memory/result addresses

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- abort  in  1  synchronous abort, returns to IDLE
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  DATA_W  received byte
- tx_busy  in  1  UART transmitter busy
- mult_done  in  1  multiplier finished, level or pulse
- rx_enable  out  1  controller accepting RX bytes
- mem_we  out  1  operand memory write enable
- mem_sel  out  1  0 = A memory, 1 = B memory
- mem_addr  out  ADDR_W  operand write address
- mem_wdata  out  DATA_W  operand write data
- m_dim, k_dim, n_dim  out  DIM_W each  latched dimensions
- mult_start  out  1  one-cycle start pulse
- tx_start  out  1  one-cycle transmit pulse
- res_addr  out  ADDR_W  result element being sent
- done  out  1  one-cycle pulse after the last result is sent
- err  out  1  sticky dimension error
- current_state  out  3  state code

## Operation
- States: IDLE=0, DIMS=1, LOAD_A=2, LOAD_B=3, COMPUTE=4, SEND=5, SEND_WAIT=6, ERROR=7.
- IDLE: rx_enable=1. On rx_valid, latch rx_data as M, set dim_idx=1, go to DIMS.
- DIMS: rx_enable=1. On rx_valid with dim_idx=1, latch K. On rx_valid with dim_idx=2, latch N and validate all three dimensions:
  - any dimension equal to 0 or greater than MAX_DIM (full DATA_W compare) → ERROR, err=1;
  - otherwise → LOAD_A with elem_cnt=0.
- LOAD_A / LOAD_B: rx_enable=1. mem_we=rx_valid, mem_addr=elem_cnt, mem_wdata=rx_data, mem_sel=0/1.
  - On each rx_valid, elem_cnt increments.
  - On the byte where elem_cnt = M·K−1 (A) or K·N−1 (B), elem_cnt resets to 0 and the state advances to LOAD_B or COMPUTE respectively.
  - Products are computed at 2·DIM_W bits; no truncation.
- COMPUTE: mult_start=1 on the first cycle only. mult_done is sampled from the second COMPUTE cycle onward. mult_done=1 → SEND with res_cnt=0.
- SEND: when tx_busy=0 → SEND_WAIT. Otherwise hold in SEND.
- SEND_WAIT:
  - First cycle: tx_start=1, res_addr=res_cnt; tx_busy is ignored this cycle (guard).
  - Later cycles, with tx_busy=0:
    - if res_cnt = M·N−1 → IDLE, done=1 for one cycle;
    - else res_cnt+1 → SEND.
- ERROR: rx_enable=0, all RX bytes are ignored. Exit only via abort or rst.
- abort=1 has priority over every transition. Next state is IDLE; elem_cnt, res_cnt, dim_idx and err are cleared; dims are retained. No pulse outputs are issued that cycle.
- rx_valid is ignored in COMPUTE, SEND and SEND_WAIT, and no memory write occurs.
- m_dim, k_dim and n_dim hold their values until the next job's dimension bytes.

## Timing
- Reset values:
  - current_state = IDLE
  - all counters = 0, m_dim = k_dim = n_dim = 0
  - mult_start, tx_start, done, err = 0
  - res_addr = 0
  - rx_enable = 1
  - mem_we = 0
- mem_we, mem_sel, mem_addr and mem_wdata are combinational and appear in the same cycle as rx_valid.
- mult_start, tx_start, done, err and res_addr are registered.
- Throughput: one operand per clk (back-to-back rx_valid accepted in every state that accepts RX).
- Latency:
  - last B byte → mult_start: 1 cycle;
  - mult_done → first tx_start: 2 cycles if tx_busy=0;
  - tx_busy falling → next tx_start: 2 cycles.
- Result transfers per job: exactly M·N tx_start pulses, with res_addr 0..M·N−1 in order.
- Minimum spacing between tx_start pulses: 3 cycles.

## Test plan
- M=2,K=3,N=2, A=1..6, B=7..12, mult_done 5 cycles after mult_start, tx_busy high 4 cycles per send → 6 A writes (sel 0, addr 0..5), then 6 B writes (sel 1); one mult_start; 4 tx_start pulses with res_addr 0,1,2,3; done once; return to IDLE.
- M=K=N=1, back-to-back rx_valid → 1 A write, 1 B write; mult_start 1 cycle after the B byte; single tx_start; done.
- MAX_DIM=8, dims 3,9,2 → ERROR, err=1; 5 further bytes produce no mem_we; abort → IDLE, err=0.
- Dims 0,4,4 → ERROR immediately after the third byte; no mult_start.
- Abort during LOAD_B after 3 bytes of 2,2,2, then a new 2,2,2 job → B/A writes restart at addr 0; full job completes normally.
- tx_busy held high for 50 cycles in SEND → no tx_start until it drops; tx_busy=1 in the guard cycle does not stall; rst asserted mid-SEND → immediate IDLE with reset values.
